boton_eventos: RTL and testbench
================================

# boton_eventos

Classifies the three debounced button levels (test, energia, sueno) from the `Boton_AR` debouncers. For each button it emits one-cycle short-press or long-press pulses, and it holds a `modo_test` level that the long press of test toggles. It sits between the debouncers and the pet state machine, so downstream logic never sees raw levels or repeated events.

## Interface

Parameters:
- `LONG_CYCLES`, default 250000000: consecutive high samples that make a long press (5 s at 50 MHz). Must be ≥ 2.
- `CNT_W`, default 28: hold-counter width. Must satisfy 2^CNT_W > LONG_CYCLES.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `test_db`  in  1  debounced test level, 1 = pressed.
- `energia_db`  in  1  debounced energia level.
- `sueno_db`  in  1  debounced sueno level.
- `test_corto`  out  1  one-cycle pulse on a short press of test.
- `test_largo`  out  1  one-cycle pulse on a long press of test.
- `energia_corto`  out  1  one-cycle pulse on a short press of energia.
- `energia_largo`  out  1  one-cycle pulse on a long press of energia.
- `sueno_corto`  out  1  one-cycle pulse on a short press of sueno.
- `sueno_largo`  out  1  one-cycle pulse on a long press of sueno.
- `modo_test`  out  1  level; toggles on every `test_largo`.

## Operation

- There are three identical, independent per-button FSMs. Each has states `IDLE`, `PULSADO` and `ESPERA`, plus a `CNT_W`-bit counter `cnt`.
- `IDLE`:
  - level = 1: go to `PULSADO`, `cnt` <= 1.
  - Otherwise stay in `IDLE`.
- `PULSADO` with level = 0: assert `corto`, go to `IDLE`, `cnt` <= 0.
- `PULSADO` with level = 1:
  - If `cnt` == LONG_CYCLES-1: assert `largo`, go to `ESPERA`.
  - Otherwise `cnt` <= `cnt` + 1.
- `ESPERA`:
  - level = 0: go to `IDLE`.
  - Otherwise stay, emitting nothing. A long press never also produces `corto` on release.
- Reset puts each FSM in `ESPERA`, with `cnt` = 0, all pulses 0 and `modo_test` = 0.
  - A button held through reset is therefore ignored until it is released.
  - Reset asserted mid-press discards the press; no event is emitted.
- Buttons never interact. Any combination of pulses may assert in the same cycle.
- `modo_test` <= ~`modo_test` on the same edge that sets `test_largo`. No other button affects it.
- `cnt` never wraps, because `PULSADO` leaves at LONG_CYCLES-1.

## Timing

- All outputs are registered, and every pulse is exactly 1 cycle wide.
- Let level first be sampled high at edge k.
  - `largo` is high in the cycle after edge k+LONG_CYCLES-1.
  - This requires level high at all LONG_CYCLES samples k through k+LONG_CYCLES-1.
- If level is sampled low at edge m, with k < m ≤ k+LONG_CYCLES-1:
  - `corto` is high in the cycle after edge m.
  - The shortest short press is 1 high sample, giving `corto` 2 cycles after the rising sample.
- Boundary at edge k+LONG_CYCLES-1:
  - Level still high there: long press.
  - Level low there: short press.
- The next press can be recognised from the first cycle after the FSM reaches `IDLE`. A new rising level in the cycle right after the `corto` edge starts a new press.
- `modo_test` changes in the same cycle that `test_largo` is high.

## Structure

- Package `boton_pkg`:
  - State encoding `IDLE`, `PULSADO`, `ESPERA` as 2-bit localparams.
  - Default constants `LONG_CYCLES_DEF` and `CNT_W_DEF`.
- Sub-module `evento_boton` holds one FSM plus its counter.
  - Parameters: `LONG_CYCLES`, `CNT_W`.
  - Ports: `clk`, `reset`, `nivel`, `corto`, `largo`.
- `boton_eventos` instantiates `evento_boton` three times and adds the `modo_test` toggle register.

## Test plan

All scenarios run with LONG_CYCLES = 8 and CNT_W = 4.

1. Reset with all inputs 0, then hold `energia_db` = 1 for 3 cycles and drop it: exactly one `energia_corto` pulse, 1 cycle wide, in the cycle after the first low sample; no `energia_largo`; `modo_test` stays 0.
2. `test_db` = 1 for 20 cycles, then 0: one `test_largo` in the cycle after the 8th high sample; `modo_test` goes 0→1 in that same cycle; no `test_corto` on release. A second identical hold returns `modo_test` to 0.
3. `sueno_db` high for exactly 7 samples: `sueno_corto` only. High for exactly 8 samples: `sueno_largo` only.
4. `test_db` held high before and during reset, released 5 cycles after reset deasserts: no pulses at all. A later 2-cycle press gives one `test_corto`.
5. All three inputs rise on the same cycle and fall 4 cycles later: `test_corto`, `energia_corto` and `sueno_corto` all assert in the same single cycle.
6. `energia_db` high for 5 cycles, then `reset` for 1 cycle, then still high for 10 cycles: no `energia_largo`, no `energia_corto`; the FSM is in `ESPERA` until the level drops.

Source files
------------

// File: rtl/boton_pkg.sv
// Shared state encoding and default timing constants for the button event classifier.
package boton_pkg;

  typedef logic [1:0] estado_t;

  localparam estado_t IDLE    = 2'd0;
  localparam estado_t PULSADO = 2'd1;
  localparam estado_t ESPERA  = 2'd2;

  // 5 s at 50 MHz; CNT_W_DEF leaves headroom so the counter never wraps.
  localparam int LONG_CYCLES_DEF = 250000000;
  localparam int CNT_W_DEF       = 28;

endpackage

// File: rtl/evento_boton.sv
// One debounced level in, registered one-cycle short/long press pulses out.
// largo_prox is the next-state value of largo, so a parent can update state on the same edge.
module evento_boton
  import boton_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic nivel,
  output logic corto,
  output logic largo,
  output logic largo_prox
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LONG_CYCLES - 1);

  estado_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             corto_q, corto_d;
  logic             largo_q, largo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ESPERA;
      cnt_q   <= '0;
      corto_q <= 1'b0;
      largo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      corto_q <= corto_d;
      largo_q <= largo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    corto_d = 1'b0;
    largo_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (nivel) begin
          state_d = PULSADO;
          cnt_d   = CNT_W'(1);
        end
      end
      PULSADO: begin
        if (!nivel) begin
          corto_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          largo_d = 1'b1;
          state_d = ESPERA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ESPERA: begin
        // Swallow the rest of a long press (or a press held through reset).
        if (!nivel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ESPERA;
        cnt_d   = '0;
      end
    endcase
  end

  assign corto      = corto_q;
  assign largo      = largo_q;
  assign largo_prox = largo_d;

endmodule

// File: rtl/boton_eventos.sv
// Three independent press classifiers (test, energia, sueno) plus the modo_test toggle,
// which flips on the same edge that raises test_largo.
module boton_eventos
  import boton_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic test_db,
  input  logic energia_db,
  input  logic sueno_db,
  output logic test_corto,
  output logic test_largo,
  output logic energia_corto,
  output logic energia_largo,
  output logic sueno_corto,
  output logic sueno_largo,
  output logic modo_test
);

  logic test_largo_prox;
  logic energia_largo_prox;
  logic sueno_largo_prox;
  logic modo_test_q, modo_test_d;

  evento_boton #(.LONG_CYCLES(LONG_CYCLES), .CNT_W(CNT_W)) u_test (
    .clk        (clk),
    .reset      (reset),
    .nivel      (test_db),
    .corto      (test_corto),
    .largo      (test_largo),
    .largo_prox (test_largo_prox)
  );

  evento_boton #(.LONG_CYCLES(LONG_CYCLES), .CNT_W(CNT_W)) u_energia (
    .clk        (clk),
    .reset      (reset),
    .nivel      (energia_db),
    .corto      (energia_corto),
    .largo      (energia_largo),
    .largo_prox (energia_largo_prox)
  );

  evento_boton #(.LONG_CYCLES(LONG_CYCLES), .CNT_W(CNT_W)) u_sueno (
    .clk        (clk),
    .reset      (reset),
    .nivel      (sueno_db),
    .corto      (sueno_corto),
    .largo      (sueno_largo),
    .largo_prox (sueno_largo_prox)
  );

  assign modo_test_d = modo_test_q ^ test_largo_prox;

  always_ff @(posedge clk) begin
    if (reset) modo_test_q <= 1'b0;
    else       modo_test_q <= modo_test_d;
  end

  assign modo_test = modo_test_q;

  // Long presses of energia/sueno are reported but never touch modo_test.
  logic unused_largo_prox;
  assign unused_largo_prox = energia_largo_prox ^ sueno_largo_prox;

endmodule

// File: tb/tb_boton_eventos.sv
// Scoreboard bench: each press pushes its expected event, the monitor pops on every pulse cycle.
module tb_boton_eventos;

  localparam int LC = 8;

  logic clk = 1'b0;
  logic reset, test_db, energia_db, sueno_db;
  logic test_corto, test_largo, energia_corto, energia_largo, sueno_corto, sueno_largo;
  logic modo_test;

  typedef struct {
    int       cyc;
    logic [5:0] mask;
    logic     modo;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic modo_exp = 1'b0;

  boton_eventos #(.LONG_CYCLES(LC), .CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .test_db       (test_db),
    .energia_db    (energia_db),
    .sueno_db      (sueno_db),
    .test_corto    (test_corto),
    .test_largo    (test_largo),
    .energia_corto (energia_corto),
    .energia_largo (energia_largo),
    .sueno_corto   (sueno_corto),
    .sueno_largo   (sueno_largo),
    .modo_test     (modo_test)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] pulses;
  assign pulses = {test_corto, test_largo, energia_corto, energia_largo, sueno_corto, sueno_largo};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (pulses != 6'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {26'b0, pulses}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_mask", {26'b0, pulses}, {26'b0, e.mask});
        chk("event_modo", {31'b0, modo_test}, {31'b0, e.modo});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    modo_exp = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // btn = {test, energia, sueno}; n = number of high samples.
  task automatic press(input logic [2:0] btn, input int n);
    exp_t e;
    logic lng;
    lng = (n >= LC);
    e.cyc = cyc + 1 + (lng ? LC - 1 : n);
    e.mask = '0;
    for (int b = 0; b < 3; b++) begin
      if (btn[b]) e.mask[2*b + (lng ? 0 : 1)] = 1'b1;
    end
    if (lng && btn[2]) modo_exp = ~modo_exp;
    e.modo = modo_exp;
    q.push_back(e);
    {test_db, energia_db, sueno_db} = btn;
    repeat (n) tick();
    {test_db, energia_db, sueno_db} = 3'b000;
    idle(3);
  endtask

  initial begin
    {test_db, energia_db, sueno_db} = 3'b000;
    reset = 1'b1;
    idle(1);
    do_reset(3);
    chk("reset_pulses", {26'b0, pulses}, 32'h0);
    chk("reset_modo", {31'b0, modo_test}, 32'h0);
    idle(2);

    // 1: short energia press
    press(3'b010, 3);
    chk("s1_modo", {31'b0, modo_test}, 32'h0);

    // 2: two long test holds toggle modo_test up then down
    press(3'b100, 20);
    chk("s2_modo_after_first", {31'b0, modo_test}, 32'h1);
    press(3'b100, 20);
    chk("s2_modo_after_second", {31'b0, modo_test}, 32'h0);

    // 3: boundary at LONG_CYCLES-1 / LONG_CYCLES samples, plus the 1-sample minimum
    press(3'b001, LC - 1);
    press(3'b001, LC);
    press(3'b001, 1);

    // 4: test held through reset is ignored, later short press works
    test_db = 1'b1;
    idle(2);
    do_reset(2);
    idle(5);
    test_db = 1'b0;
    idle(3);
    press(3'b100, 2);

    // 5: simultaneous short presses
    press(3'b111, 4);

    // 6: reset mid-press discards it, FSM waits for release
    energia_db = 1'b1;
    idle(5);
    do_reset(1);
    idle(10);
    chk("s6_no_pulse_held", {26'b0, pulses}, 32'h0);
    energia_db = 1'b0;
    idle(3);
    press(3'b010, 3);

    // Back-to-back: new rise right after the corto edge starts a new press
    begin
      exp_t e1, e2;
      e1.cyc = cyc + 1 + 2; e1.mask = 6'b000010; e1.modo = modo_exp;
      e2.cyc = cyc + 1 + 2 + 1 + 2; e2.mask = 6'b000010; e2.modo = modo_exp;
      q.push_back(e1);
      q.push_back(e2);
      sueno_db = 1'b1; idle(2);
      sueno_db = 1'b0; idle(1);
      sueno_db = 1'b1; idle(2);
      sueno_db = 1'b0; idle(3);
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    chk("queue_drained", q.size(), 32'h0);
    chk("final_modo", {31'b0, modo_test}, {31'b0, modo_exp});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
